// File: rtl/wb_cmd_master_if.sv
// Bundle of the command stream, the response stream and the Wishbone
// initiator signals around wb_cmd_master.
//   master : view of wb_cmd_master (consumes commands, drives the bus)
//   slave  : view of the command source / response sink / Wishbone slave
interface wb_cmd_master_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  // command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_adr;
  logic [DATA_W-1:0] cmd_dat;
  logic [SEL_W-1:0]  cmd_sel;
  // response stream
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_dat;
  logic [1:0]        rsp_status;
  // Wishbone initiator
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic [SEL_W-1:0]  wb_sel_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_i;
  logic              wb_err_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_status,
    input  rsp_ready,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_status,
    output rsp_ready,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator fed by a valid/ready command
// stream. One command at a time: run one bus cycle with a bounded wait,
// then return data/status on a valid/ready response stream.
// Ports:
//   wb_clk_i   clock
//   wb_rst_ni  asynchronous active-low reset
//   bus        wb_cmd_master_if.master (cmd_*, rsp_*, wb_* signals)
//   err_count  saturating count of bus-error and timeout responses
// rsp_status: 00 OK, 10 bus error, 11 timeout. All outputs are registered.
module wb_cmd_master #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16   // 2..255 cycles of stb before abort
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  wb_cmd_master_if.master  bus,
  output logic [7:0]       err_count
);
  localparam int SEL_W = DATA_W / 8;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b10;
  localparam logic [1:0] ST_TO  = 2'b11;

  // wait counter value in the last allowed stb cycle
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic              cyc_q, cyc_d;       // drives both cyc and stb
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic accept, expired, bus_done;

  // cmd_ready is only registered high in IDLE, so it alone qualifies acceptance
  assign accept   = bus.cmd_valid & cmd_ready_q;
  assign expired  = (cnt_q == CNT_LAST);
  assign bus_done = bus.wb_err_i | bus.wb_ack_i | expired;

  // ---- state register + registered outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // ---- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)         state_d = BUS;
      BUS:     if (bus_done)       state_d = RESP;
      RESP:    if (bus.rsp_ready)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // ---- next values of the registered outputs
  always_comb begin
    cnt_d        = cnt_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    err_cnt_d    = err_cnt_q;
    unique case (state_q)
      IDLE: begin
        // also raises cmd_ready on the first edge out of reset
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          we_d        = bus.cmd_we;
          adr_d       = bus.cmd_adr;
          dat_d       = bus.cmd_dat;
          sel_d       = bus.cmd_sel;
          cnt_d       = '0;
        end
      end
      BUS: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_done) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          // err beats ack; either beats the timeout in the expiring cycle
          if (bus.wb_err_i) begin
            rsp_status_d = ST_ERR;
            rsp_dat_d    = '0;
          end else if (bus.wb_ack_i) begin
            rsp_status_d = ST_OK;
            rsp_dat_d    = we_q ? '0 : bus.wb_dat_i;
          end else begin
            rsp_status_d = ST_TO;
            rsp_dat_d    = '0;
          end
          if ((bus.wb_err_i || !bus.wb_ack_i) && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_dat    = rsp_dat_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.wb_cyc_o   = cyc_q;
  assign bus.wb_stb_o   = cyc_q;
  assign bus.wb_we_o    = we_q;
  assign bus.wb_adr_o   = adr_q;
  assign bus.wb_dat_o   = dat_q;
  assign bus.wb_sel_o   = sel_q;
  assign err_count      = err_cnt_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed + randomized bench for wb_cmd_master. The slave is played from the
// stimulus sequence; expected results come from a transaction-level model
// (stb duration, status, data, saturating error tally).
module tb_wb_cmd_master;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;
  localparam int SEL_W   = 4;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
    logic [SEL_W-1:0]  sel;
  } cmd_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;   // model of err_count

  always #5 clk = ~clk;

  wb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus),
    .err_count (err_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.we  = 1'($urandom_range(0, 1));
    c.adr = ADDR_W'($urandom);
    c.dat = $urandom;
    c.sel = SEL_W'($urandom);
    return c;
  endfunction

  // kind: 0 ack, 1 err, 2 ack+err. resp_cyc: stb cycle (1-based) in which the
  // slave answers; anything beyond TIMEOUT means the slave stays silent.
  // hold: cycles rsp_ready stays low, with nxt offered on the command port.
  task automatic do_xfer(input cmd_t c, input int kind, input int resp_cyc,
                         input logic [DATA_W-1:0] rdata, input int hold,
                         input cmd_t nxt);
    int w, n;
    bit done;
    int en;
    logic [1:0] es;
    logic [DATA_W-1:0] ed;
    // transaction-level expectation
    if (resp_cyc <= TIMEOUT) begin
      en = resp_cyc;
      es = (kind != 0) ? 2'b10 : 2'b00;
      ed = (kind == 0 && !c.we) ? rdata : '0;
    end else begin
      en = TIMEOUT;
      es = 2'b11;
      ed = '0;
    end
    if (es != 2'b00 && exp_err < 255) exp_err++;

    bus.cmd_valid = 1'b1;
    bus.cmd_we = c.we; bus.cmd_adr = c.adr; bus.cmd_dat = c.dat; bus.cmd_sel = c.sel;
    w = 0;
    while (!bus.cmd_ready && w < 20) begin @(negedge clk); w++; end
    check("accept_latency", 64'(w), 64'(0));
    @(posedge clk); #1 bus.cmd_valid = 1'b0;

    n = 0; done = 0;
    for (int k = 1; k <= TIMEOUT + 4 && !done; k++) begin
      @(negedge clk);
      bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
      if (bus.wb_stb_o) begin
        n++;
        check("cyc_with_stb", 64'(bus.wb_cyc_o), 64'(1));
        check("wb_we",  64'(bus.wb_we_o),  64'(c.we));
        check("wb_adr", 64'(bus.wb_adr_o), 64'(c.adr));
        check("wb_dat", 64'(bus.wb_dat_o), 64'(c.dat));
        check("wb_sel", 64'(bus.wb_sel_o), 64'(c.sel));
        check("rsp_valid_busy", 64'(bus.rsp_valid), 64'(0));
        bus.wb_dat_i = $urandom;
        if (k == resp_cyc) begin
          bus.wb_ack_i = (kind != 1);
          bus.wb_err_i = (kind != 0);
          bus.wb_dat_i = rdata;
        end
      end else done = 1;
    end
    check("stb_cycles", 64'(n), 64'(en));
    check("cyc_low", 64'(bus.wb_cyc_o), 64'(0));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(1));
    check("rsp_status", 64'(bus.rsp_status), 64'(es));
    check("rsp_dat", 64'(bus.rsp_dat), 64'(ed));
    check("err_count", 64'(err_count), 64'(exp_err));

    // backpressure, with stray strobes that must be ignored in RESP
    bus.cmd_valid = (hold > 0);
    bus.cmd_we = nxt.we; bus.cmd_adr = nxt.adr; bus.cmd_dat = nxt.dat; bus.cmd_sel = nxt.sel;
    for (int h = 0; h < hold; h++) begin
      bus.wb_ack_i = h[0];
      bus.wb_err_i = 1'b1;
      @(negedge clk);
      check("hold_rsp_valid", 64'(bus.rsp_valid), 64'(1));
      check("hold_rsp_status", 64'(bus.rsp_status), 64'(es));
      check("hold_rsp_dat", 64'(bus.rsp_dat), 64'(ed));
      check("hold_cmd_ready", 64'(bus.cmd_ready), 64'(0));
      check("hold_cyc", 64'(bus.wb_cyc_o), 64'(0));
      check("hold_err_count", 64'(err_count), 64'(exp_err));
    end
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("post_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("post_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("post_cyc", 64'(bus.wb_cyc_o), 64'(0));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c, nxt;
    int w;
    bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_adr = '0; bus.cmd_dat = '0; bus.cmd_sel = '0;
    bus.rsp_ready = 0; bus.wb_dat_i = '0; bus.wb_ack_i = 0; bus.wb_err_i = 0;

    // ---- reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_rsp_dat", 64'(bus.rsp_dat), 64'(0));
    check("rst_rsp_status", 64'(bus.rsp_status), 64'(0));
    check("rst_cyc", 64'(bus.wb_cyc_o), 64'(0));
    check("rst_stb", 64'(bus.wb_stb_o), 64'(0));
    check("rst_we", 64'(bus.wb_we_o), 64'(0));
    check("rst_adr", 64'(bus.wb_adr_o), 64'(0));
    check("rst_dat", 64'(bus.wb_dat_o), 64'(0));
    check("rst_sel", 64'(bus.wb_sel_o), 64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));
    rst_n = 1'b1;
    #1 check("cmd_ready_before_edge", 64'(bus.cmd_ready), 64'(0));
    @(negedge clk);
    check("cmd_ready_first_edge", 64'(bus.cmd_ready), 64'(1));

    // stray strobes in IDLE are ignored
    bus.wb_ack_i = 1; bus.wb_err_i = 1;
    repeat (2) @(negedge clk);
    bus.wb_ack_i = 0; bus.wb_err_i = 0;
    check("idle_stray_err_count", 64'(err_count), 64'(0));
    check("idle_stray_cyc", 64'(bus.wb_cyc_o), 64'(0));

    // ---- directed cases
    c = '{we: 1'b1, adr: 6'h04, dat: 32'h00AA55FF, sel: 4'hF};
    do_xfer(c, 0, 1, 32'hDEADBEEF, 0, c);            // zero-wait write
    c = '{we: 1'b0, adr: 6'h08, dat: 32'h0, sel: 4'hF};
    do_xfer(c, 0, 4, 32'h12345678, 0, c);            // 3 wait states read
    do_xfer(c, 0, TIMEOUT + 5, 32'h0, 0, c);         // silent slave -> timeout
    do_xfer(c, 0, TIMEOUT, 32'hCAFEF00D, 0, c);      // ack in expiring cycle
    do_xfer(c, 1, TIMEOUT, 32'h0, 0, c);             // err in expiring cycle
    do_xfer(c, 2, 2, 32'h55AA55AA, 0, c);            // ack+err -> err

    // backpressure with a second command waiting
    nxt = '{we: 1'b1, adr: 6'h3C, dat: 32'hA5A5_0F0F, sel: 4'h3};
    do_xfer(c, 0, 1, 32'h11112222, 10, nxt);
    do_xfer(nxt, 0, 3, 32'h0, 0, nxt);

    // ---- randomized transactions
    for (int i = 0; i < 40; i++) begin
      c   = rnd_cmd();
      nxt = rnd_cmd();
      do_xfer(c, int'($urandom_range(0, 2)), int'($urandom_range(1, TIMEOUT + 2)),
              $urandom, int'($urandom_range(0, 3)), nxt);
      if (i % 2 == 0) do_xfer(nxt, 0, int'($urandom_range(1, 3)), $urandom, 0, nxt);
    end

    // ---- saturation
    for (int i = 0; i < 300; i++) do_xfer(rnd_cmd(), 1, 1, 32'h0, 0, c);
    check("err_count_saturated", 64'(err_count), 64'(255));

    // ---- asynchronous reset mid-transfer
    c = rnd_cmd();
    bus.cmd_valid = 1; bus.cmd_we = c.we; bus.cmd_adr = c.adr; bus.cmd_dat = c.dat; bus.cmd_sel = c.sel;
    w = 0;
    while (!bus.cmd_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1 bus.cmd_valid = 0;
    @(negedge clk); @(negedge clk);
    check("pre_reset_stb", 64'(bus.wb_stb_o), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cyc", 64'(bus.wb_cyc_o), 64'(0));
    check("async_rst_stb", 64'(bus.wb_stb_o), 64'(0));
    exp_err = 0;
    check("async_rst_err_count", 64'(err_count), 64'(exp_err));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_cmd_ready_low", 64'(bus.cmd_ready), 64'(0));
    @(negedge clk);
    check("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("post_rst_cyc", 64'(bus.wb_cyc_o), 64'(0));
    do_xfer(rnd_cmd(), 0, 2, 32'h0BADF00D, 1, c);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic single-transfer initiator that drives the GPIO controller's Wishbone slave port (the `wb_*` interface of the pad/mux/GPIO top level) from a simple valid/ready command stream. It does the following:
- Accepts one command at a time.
- Runs one Wishbone cycle with a bounded wait for the slave's response.
- Returns read data and status on a valid/ready response stream.
- Counts bus errors.

It sits between a CPU-side/test-sequencer command source and the GPIO register block.

## Interface
Parameters:
- ADDR_W, 6, Wishbone address width
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles with stb high before abort (2..255)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  ADDR_W  register address
- cmd_dat  in  DATA_W  write data
- cmd_sel  in  DATA_W/8  byte selects
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_dat  out  DATA_W  read data (0 for writes, errors, timeouts)
- rsp_status  out  2  00 OK, 10 bus error, 11 timeout
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone strobes
- wb_adr_o  out  ADDR_W
- wb_dat_o  out  DATA_W
- wb_sel_o  out  DATA_W/8
- wb_dat_i  in  DATA_W
- wb_ack_i, wb_err_i  in  1 each
- err_count  out  8  saturating count of error and timeout responses

## Operation
FSM states are IDLE, BUS and RESP.

- **IDLE**
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch we/adr/dat/sel into wb_*_o, set wb_cyc_o=wb_stb_o=1, clear wait counter, go to BUS. cmd_ready drops in the same edge.
- **BUS**
  - wb_cyc_o/stb_o held high and all wb_*_o stable. Wait counter increments each cycle.
  - wb_err_i=1: rsp_status=10, rsp_dat=0, err_count+1. err wins if ack and err are both high.
  - else wb_ack_i=1: rsp_status=00, rsp_dat=wb_dat_i for reads, 0 for writes.
  - else counter==TIMEOUT-1: rsp_status=11, rsp_dat=0, err_count+1.
  - Any of the three exit conditions drops cyc/stb, sets rsp_valid=1 and goes to RESP.
  - An ack or err arriving in the expiring cycle takes priority over the timeout.
- **RESP**
  - rsp_valid, rsp_dat and rsp_status are held stable until rsp_ready.
  - On rsp_valid&rsp_ready: clear rsp_valid, set cmd_ready=1, go to IDLE.
- wb_ack_i/wb_err_i seen in IDLE or RESP are ignored and do not affect err_count.
- err_count saturates at 255 and is cleared only by reset.
- wb_we_o, wb_adr_o, wb_dat_o and wb_sel_o hold their last values outside BUS.

## Timing
- All outputs are registered.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_dat=0, rsp_status=00, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o/dat_o/sel_o=0, err_count=0, state IDLE.
- cmd_ready rises at the first wb_clk_i edge after wb_rst_ni deasserts.
- Reset assertion mid-transfer drops cyc/stb immediately (asynchronously); the transfer is discarded and no response is issued.
- Acceptance at edge E0 gives cyc/stb high in cycle 1.
- A slave ack sampled at the end of cycle k gives cyc/stb low and rsp_valid high in cycle k+1. Zero-wait slave: rsp_valid in cycle 2.
- No ack: stb stays high for exactly TIMEOUT cycles; rsp_valid=1 in cycle TIMEOUT+1.
- rsp_ready held high: next command is accepted at the earliest one cycle after rsp handshake. Back-to-back throughput is one transfer per 3+wait cycles.
- cyc and stb are always asserted and deasserted together; no bursts, no retry.

## Test plan
- Reset then write: cmd_we=1, adr=0x04, dat=0x00AA55FF, sel=0xF, slave acks in the first stb cycle → cyc/stb high exactly one cycle with those values; rsp_valid next cycle with status 00, rsp_dat=0; err_count=0.
- Read with 3 wait states: slave returns 0x12345678 on ack in the 4th stb cycle → stb high 4 cycles; rsp_dat=0x12345678, status 00.
- Silent slave with TIMEOUT=16 → stb high exactly 16 cycles, then status 11, rsp_dat=0, err_count=1. Same case with ack in cycle 16 → status 00.
- Simultaneous ack+err on a read → status 10, rsp_dat=0, err_count increments. 300 err responses → err_count=255.
- Backpressure: hold rsp_ready=0 for 10 cycles while cmd_valid=1 with a second command → rsp fields stable, cmd_ready=0, no new cyc. On release, second command cyc rises one cycle after the rsp handshake.
- Assert wb_rst_ni=0 while stb is high → cyc/stb=0 without a clock edge; after release no rsp_valid, and cmd_ready=1 after the first edge.
